// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the Smith-Waterman job arbiter slice.
//   SW_SEQ_MAX : default maximum sequence length in bases
//   SW_SCORE_W : default signed score width
//   SW_LEN_W   : default length field width (1-based length, so one extra bit)
//   SW_TAG_W   : requester job tag width
//   state_e    : arbiter FSM states
// -----------------------------------------------------------------------------
package sw_pkg;

   localparam int SW_SEQ_MAX = 128;
   localparam int SW_SCORE_W = 10;
   localparam int SW_LEN_W   = $clog2(SW_SEQ_MAX) + 1;
   localparam int SW_TAG_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin requester selection. The search starts at the index following
// the last accepted grant (index 0 after reset). The grant is combinational;
// the pointer only moves on a clock edge where i_advance is high and some
// request is present, so a requester that drops its request before that edge
// simply loses its turn without disturbing the rotation.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_req        : N-bit request vector
//   i_advance    : grant is being taken this cycle
//   o_grant      : one-hot grant
//   o_grant_idx  : binary index of the granted requester
//   o_any        : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N     = 2,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     i_req,
   input  logic             i_advance,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_rot_idx [N];

   // w_rot_idx[k] is the requester index examined k places after the pointer.
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign w_rot_idx[gi] = IDX_W'((int'(r_ptr) + gi) % N);
   end

   // Scan from the farthest position back toward the pointer so the last
   // hit written is the nearest one in round-robin order.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[w_rot_idx[i]]) begin
            o_any       = 1'b1;
            o_grant_idx = w_rot_idx[i];
         end
      end
      if (o_any) begin
         o_grant[o_grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_advance && o_any) begin
         r_ptr <= (o_grant_idx == IDX_W'(N - 1)) ? '0 : o_grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/sw_job_arbiter.sv
// -----------------------------------------------------------------------------
// sw_job_arbiter
// Shares one Smith-Waterman core between N_REQ requesters, one job at a time.
// A requester is granted round-robin while idle, its job is latched, checked
// for legal lengths, issued to the core, and the core result is returned with
// the requester index and tag. Jobs with an illegal length are answered with
// resp_err=1 and never reach the core.
// Per-requester buses are packed with requester i at bit offset i*W.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid / req_ready           : per-requester job handshake
//   req_ref, req_read               : sequences, 2 bits per base, MSB-first
//   req_ref_len, req_read_len       : 1-based lengths
//   req_tag                         : job tag echoed in the response
//   core_valid / core_ready         : job handshake to the SW core
//   core_ref, core_read, core_*_len : latched job presented to the core
//   core_res_valid / core_res_ready : result handshake from the SW core
//   core_score, core_column, core_row : best score and its location
//   resp_valid / resp_ready         : response handshake
//   resp_id, resp_tag, resp_score, resp_column, resp_row, resp_err : response
//   stat_jobs                       : completed good jobs, saturating
//   stat_busy                       : cycles in ISSUE or WAIT, saturating
// -----------------------------------------------------------------------------
module sw_job_arbiter
   import sw_pkg::*;
#(
   parameter  int N_REQ   = 2,
   parameter  int SEQ_MAX = SW_SEQ_MAX,
   parameter  int SCORE_W = SW_SCORE_W,
   localparam int SEQ_W   = 2 * SEQ_MAX,
   localparam int LEN_W   = $clog2(SEQ_MAX) + 1,
   localparam int POS_W   = $clog2(SEQ_MAX),
   localparam int ID_W    = $clog2(N_REQ),
   localparam int TAG_W   = SW_TAG_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*SEQ_W-1:0]    req_ref,
   input  logic [N_REQ*SEQ_W-1:0]    req_read,
   input  logic [N_REQ*LEN_W-1:0]    req_ref_len,
   input  logic [N_REQ*LEN_W-1:0]    req_read_len,
   input  logic [N_REQ*TAG_W-1:0]    req_tag,
   output logic                      core_valid,
   input  logic                      core_ready,
   output logic [SEQ_W-1:0]          core_ref,
   output logic [SEQ_W-1:0]          core_read,
   output logic [LEN_W-1:0]          core_ref_len,
   output logic [LEN_W-1:0]          core_read_len,
   input  logic                      core_res_valid,
   output logic                      core_res_ready,
   input  logic signed [SCORE_W-1:0] core_score,
   input  logic [POS_W-1:0]          core_column,
   input  logic [POS_W-1:0]          core_row,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [ID_W-1:0]           resp_id,
   output logic [TAG_W-1:0]          resp_tag,
   output logic signed [SCORE_W-1:0] resp_score,
   output logic [POS_W-1:0]          resp_column,
   output logic [POS_W-1:0]          resp_row,
   output logic                      resp_err,
   output logic [15:0]               stat_jobs,
   output logic [23:0]               stat_busy
);

   // ---------------------------------------------------------------- unpack
   logic [SEQ_W-1:0] w_ref      [N_REQ];
   logic [SEQ_W-1:0] w_read     [N_REQ];
   logic [LEN_W-1:0] w_ref_len  [N_REQ];
   logic [LEN_W-1:0] w_read_len [N_REQ];
   logic [TAG_W-1:0] w_tag      [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_ref[gi]      = req_ref[gi*SEQ_W +: SEQ_W];
      assign w_read[gi]     = req_read[gi*SEQ_W +: SEQ_W];
      assign w_ref_len[gi]  = req_ref_len[gi*LEN_W +: LEN_W];
      assign w_read_len[gi] = req_read_len[gi*LEN_W +: LEN_W];
      assign w_tag[gi]      = req_tag[gi*TAG_W +: TAG_W];
   end

   // ------------------------------------------------------------- arbitration
   state_e            r_state;
   logic              w_idle;
   logic [N_REQ-1:0]  w_grant;
   logic [ID_W-1:0]   w_grant_idx;
   logic              w_any;

   assign w_idle = (r_state == ST_IDLE);

   rr_arbiter #(.N(N_REQ)) u_rr (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (req_valid),
      .i_advance   (w_idle),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any       (w_any)
   );

   // Ready is only offered in IDLE, so the grant and the latch below happen
   // on the same edge and the pulse can never be longer than one cycle.
   assign req_ready = w_idle ? w_grant : '0;

   // Length legality is judged on the granted requester's inputs so an
   // illegal job goes straight from IDLE to ERR without touching the core.
   logic [LEN_W-1:0] w_sel_ref_len;
   logic [LEN_W-1:0] w_sel_read_len;
   logic             w_len_ok;

   assign w_sel_ref_len  = w_ref_len[w_grant_idx];
   assign w_sel_read_len = w_read_len[w_grant_idx];
   assign w_len_ok = (w_sel_ref_len  != '0) && (w_sel_ref_len  <= LEN_W'(SEQ_MAX)) &&
                     (w_sel_read_len != '0) && (w_sel_read_len <= LEN_W'(SEQ_MAX));

   // -------------------------------------------------------------------- FSM
   logic [SEQ_W-1:0]          r_ref;
   logic [SEQ_W-1:0]          r_read;
   logic [LEN_W-1:0]          r_ref_len;
   logic [LEN_W-1:0]          r_read_len;
   logic [TAG_W-1:0]          r_tag;
   logic [ID_W-1:0]           r_id;
   logic                      r_core_valid;
   logic                      r_core_res_ready;
   logic                      r_resp_valid;
   logic                      r_resp_err;
   logic signed [SCORE_W-1:0] r_resp_score;
   logic [POS_W-1:0]          r_resp_column;
   logic [POS_W-1:0]          r_resp_row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= ST_IDLE;
         r_ref            <= '0;
         r_read           <= '0;
         r_ref_len        <= '0;
         r_read_len       <= '0;
         r_tag            <= '0;
         r_id             <= '0;
         r_core_valid     <= 1'b0;
         r_core_res_ready <= 1'b0;
         r_resp_valid     <= 1'b0;
         r_resp_err       <= 1'b0;
         r_resp_score     <= '0;
         r_resp_column    <= '0;
         r_resp_row       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_ref      <= w_ref[w_grant_idx];
                  r_read     <= w_read[w_grant_idx];
                  r_ref_len  <= w_sel_ref_len;
                  r_read_len <= w_sel_read_len;
                  r_tag      <= w_tag[w_grant_idx];
                  r_id       <= w_grant_idx;
                  if (w_len_ok) begin
                     r_core_valid <= 1'b1;
                     r_state      <= ST_ISSUE;
                  end else begin
                     r_resp_valid  <= 1'b1;
                     r_resp_err    <= 1'b1;
                     r_resp_score  <= '0;
                     r_resp_column <= '0;
                     r_resp_row    <= '0;
                     r_state       <= ST_ERR;
                  end
               end
            end
            ST_ISSUE: begin
               if (core_ready) begin
                  r_core_valid     <= 1'b0;
                  r_core_res_ready <= 1'b1;
                  r_state          <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (core_res_valid) begin
                  r_core_res_ready <= 1'b0;
                  r_resp_score     <= core_score;
                  r_resp_column    <= core_column;
                  r_resp_row       <= core_row;
                  r_resp_err       <= 1'b0;
                  r_resp_valid     <= 1'b1;
                  r_state          <= ST_RESP;
               end
            end
            ST_RESP, ST_ERR: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_resp_err   <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------- statistics
   logic [15:0] r_stat_jobs;
   logic [23:0] r_stat_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_jobs <= '0;
         r_stat_busy <= '0;
      end else begin
         if ((r_state == ST_RESP) && resp_ready && (r_stat_jobs != 16'hFFFF)) begin
            r_stat_jobs <= r_stat_jobs + 16'd1;
         end
         if (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && (r_stat_busy != 24'hFF_FFFF)) begin
            r_stat_busy <= r_stat_busy + 24'd1;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign core_valid     = r_core_valid;
   assign core_ref       = r_ref;
   assign core_read      = r_read;
   assign core_ref_len   = r_ref_len;
   assign core_read_len  = r_read_len;
   assign core_res_ready = r_core_res_ready;
   assign resp_valid     = r_resp_valid;
   assign resp_id        = r_id;
   assign resp_tag       = r_tag;
   assign resp_score     = r_resp_score;
   assign resp_column    = r_resp_column;
   assign resp_row       = r_resp_row;
   assign resp_err       = r_resp_err;
   assign stat_jobs      = r_stat_jobs;
   assign stat_busy      = r_stat_busy;

endmodule

// File: tb/tb_sw_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sw_job_arbiter
// Directed bench for sw_job_arbiter with the default parameters (2 requesters,
// 128-base sequences, 10-bit score). The SW core and the response consumer
// are played cycle by cycle from the test tasks. Inputs change 1 time unit
// after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_sw_job_arbiter;

   localparam int N_REQ   = 2;
   localparam int SEQ_MAX = 128;
   localparam int SCORE_W = 10;
   localparam int SEQ_W   = 256;
   localparam int LEN_W   = 8;
   localparam int POS_W   = 7;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic [N_REQ-1:0]          req_valid = '0;
   logic [N_REQ-1:0]          req_ready;
   logic [N_REQ*SEQ_W-1:0]    req_ref = '0;
   logic [N_REQ*SEQ_W-1:0]    req_read = '0;
   logic [N_REQ*LEN_W-1:0]    req_ref_len = '0;
   logic [N_REQ*LEN_W-1:0]    req_read_len = '0;
   logic [N_REQ*4-1:0]        req_tag = '0;
   logic                      core_valid;
   logic                      core_ready = 1'b0;
   logic [SEQ_W-1:0]          core_ref;
   logic [SEQ_W-1:0]          core_read;
   logic [LEN_W-1:0]          core_ref_len;
   logic [LEN_W-1:0]          core_read_len;
   logic                      core_res_valid = 1'b0;
   logic                      core_res_ready;
   logic signed [SCORE_W-1:0] core_score = '0;
   logic [POS_W-1:0]          core_column = '0;
   logic [POS_W-1:0]          core_row = '0;
   logic                      resp_valid;
   logic                      resp_ready = 1'b0;
   logic                      resp_id;
   logic [3:0]                resp_tag;
   logic signed [SCORE_W-1:0] resp_score;
   logic [POS_W-1:0]          resp_column;
   logic [POS_W-1:0]          resp_row;
   logic                      resp_err;
   logic [15:0]               stat_jobs;
   logic [23:0]               stat_busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [SEQ_W-1:0] seq_a, seq_b, seq_c, seq_d, seq_full;

   always #5 clk = ~clk;

   sw_job_arbiter #(.N_REQ(N_REQ), .SEQ_MAX(SEQ_MAX), .SCORE_W(SCORE_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ref(req_ref), .req_read(req_read),
      .req_ref_len(req_ref_len), .req_read_len(req_read_len), .req_tag(req_tag),
      .core_valid(core_valid), .core_ready(core_ready),
      .core_ref(core_ref), .core_read(core_read),
      .core_ref_len(core_ref_len), .core_read_len(core_read_len),
      .core_res_valid(core_res_valid), .core_res_ready(core_res_ready),
      .core_score(core_score), .core_column(core_column), .core_row(core_row),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_tag(resp_tag), .resp_score(resp_score),
      .resp_column(resp_column), .resp_row(resp_row), .resp_err(resp_err),
      .stat_jobs(stat_jobs), .stat_busy(stat_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [SEQ_W-1:0] rs, input logic [SEQ_W-1:0] ds,
                          input logic [LEN_W-1:0] rl, input logic [LEN_W-1:0] dl, input logic [3:0] tg);
      req_ref[r*SEQ_W +: SEQ_W]      = rs;
      req_read[r*SEQ_W +: SEQ_W]     = ds;
      req_ref_len[r*LEN_W +: LEN_W]  = rl;
      req_read_len[r*LEN_W +: LEN_W] = dl;
      req_tag[r*4 +: 4]              = tg;
   endtask

   // ------------------------------------------------------------------ reset
   task automatic test_reset();
      #2 rst_n = 1'b0;
      step();
      step();
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      n_cmp++; if ({core_valid, core_res_ready, resp_valid, resp_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {core_valid, core_res_ready, resp_valid, resp_err}); end
      n_cmp++; if ({stat_jobs, stat_busy} !== 40'd0) begin n_bad++; $display("FAIL reset_stats: got jobs=%0d busy=%0d want 0/0", stat_jobs, stat_busy); end
      n_cmp++; if ({core_ref_len, core_read_len, resp_tag, resp_score} !== 30'd0) begin n_bad++; $display("FAIL reset_data: got lens=%0d/%0d tag=%0d score=%0d want 0", core_ref_len, core_read_len, resp_tag, resp_score); end
      rst_n = 1'b1;
      step();
   endtask

   // ------------------------------------------------------------- single job
   task automatic test_single();
      set_req(0, seq_a, seq_b, 8'd8, 8'd8, 4'h5);
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", req_ready); end
      step();
      req_valid = 2'b00;
      n_cmp++; if (core_valid !== 1'b1) begin n_bad++; $display("FAIL single_core_valid_latency: got %b want 1", core_valid); end
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL single_ready_pulse: got %b want 00", req_ready); end
      n_cmp++; if ({core_ref, core_read} !== {seq_a, seq_b}) begin n_bad++; $display("FAIL single_core_seq: got %h want %h", core_ref[255:240], seq_a[255:240]); end
      n_cmp++; if ({core_ref_len, core_read_len} !== {8'd8, 8'd8}) begin n_bad++; $display("FAIL single_core_len: got %0d/%0d want 8/8", core_ref_len, core_read_len); end
      core_ready = 1'b1;
      step();
      core_ready = 1'b0;
      n_cmp++; if ({core_valid, core_res_ready} !== 2'b01) begin n_bad++; $display("FAIL single_wait: got valid=%b res_ready=%b want 0/1", core_valid, core_res_ready); end
      core_res_valid = 1'b1; core_score = 10'sd8; core_column = 7'd7; core_row = 7'd7;
      step();
      core_res_valid = 1'b0;
      n_cmp++; if ({resp_valid, resp_err, resp_id, resp_tag} !== {1'b1, 1'b0, 1'b0, 4'h5}) begin n_bad++; $display("FAIL single_resp_hdr: got v=%b err=%b id=%0d tag=%0d want 1/0/0/5", resp_valid, resp_err, resp_id, resp_tag); end
      n_cmp++; if ({resp_score, resp_column, resp_row} !== {10'sd8, 7'd7, 7'd7}) begin n_bad++; $display("FAIL single_resp_data: got score=%0d col=%0d row=%0d want 8/7/7", resp_score, resp_column, resp_row); end
      $display("txn single id=%0d tag=%0d score=%0d col=%0d row=%0d err=%0d", resp_id, resp_tag, resp_score, resp_column, resp_row, resp_err);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_resp_drop: got %b want 0", resp_valid); end
      n_cmp++; if ({stat_jobs, stat_busy} !== {16'd1, 24'd2}) begin n_bad++; $display("FAIL single_stats: got jobs=%0d busy=%0d want 1/2", stat_jobs, stat_busy); end
   endtask

   // --------------------------------------------------------- illegal length
   task automatic test_error();
      // ref_len one past the maximum, requester 0
      set_req(0, seq_a, seq_b, 8'd129, 8'd8, 4'h6);
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL err_long_grant: got %b want 01", req_ready); end
      step();
      req_valid = 2'b00;
      n_cmp++; if ({resp_valid, resp_err, resp_id, resp_tag, core_valid} !== {1'b1, 1'b1, 1'b0, 4'h6, 1'b0}) begin n_bad++; $display("FAIL err_long_resp: got v=%b err=%b id=%0d tag=%0d core_valid=%b want 1/1/0/6/0", resp_valid, resp_err, resp_id, resp_tag, core_valid); end
      n_cmp++; if ({resp_score, resp_column, resp_row} !== 24'd0) begin n_bad++; $display("FAIL err_long_zero: got score=%0d col=%0d row=%0d want 0/0/0", resp_score, resp_column, resp_row); end
      $display("txn err id=%0d tag=%0d err=%0d", resp_id, resp_tag, resp_err);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      n_cmp++; if ({resp_valid, core_valid} !== 2'b00) begin n_bad++; $display("FAIL err_long_done: got v=%b core_valid=%b want 0/0", resp_valid, core_valid); end
      // read_len zero, requester 1
      set_req(1, seq_c, seq_d, 8'd8, 8'd0, 4'h9);
      req_valid = 2'b10;
      #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL err_zero_grant: got %b want 10", req_ready); end
      step();
      req_valid = 2'b00;
      n_cmp++; if ({resp_valid, resp_err, resp_id, resp_tag, core_valid} !== {1'b1, 1'b1, 1'b1, 4'h9, 1'b0}) begin n_bad++; $display("FAIL err_zero_resp: got v=%b err=%b id=%0d tag=%0d core_valid=%b want 1/1/1/9/0", resp_valid, resp_err, resp_id, resp_tag, core_valid); end
      $display("txn err id=%0d tag=%0d err=%0d", resp_id, resp_tag, resp_err);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      n_cmp++; if ({resp_valid, core_valid} !== 2'b00) begin n_bad++; $display("FAIL err_zero_done: got v=%b core_valid=%b want 0/0", resp_valid, core_valid); end
      n_cmp++; if ({stat_jobs, stat_busy} !== {16'd1, 24'd2}) begin n_bad++; $display("FAIL err_stats: got jobs=%0d busy=%0d want 1/2", stat_jobs, stat_busy); end
   endtask

   // ------------------------------------------------------------ round robin
   task automatic test_round_robin();
      logic [3:0] exp_tag [4];
      logic [1:0] exp_gnt;
      logic [7:0] exp_len;
      int         g;
      exp_tag[0] = 4'hA; exp_tag[1] = 4'hC; exp_tag[2] = 4'hB; exp_tag[3] = 4'hD;
      set_req(0, seq_a, seq_b, 8'd8, 8'd8, 4'hA);
      set_req(1, seq_c, seq_d, 8'd16, 8'd12, 4'hC);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         g = k % 2;
         exp_gnt = (g == 0) ? 2'b01 : 2'b10;
         exp_len = (g == 0) ? 8'd8 : 8'd16;
         #1;
         n_cmp++; if (req_ready !== exp_gnt) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_gnt); end
         step();
         if (k == 0) set_req(0, seq_a, seq_b, 8'd8, 8'd8, 4'hB);
         if (k == 1) set_req(1, seq_c, seq_d, 8'd16, 8'd12, 4'hD);
         n_cmp++; if ({core_valid, core_ref_len} !== {1'b1, exp_len}) begin n_bad++; $display("FAIL rr_issue[%0d]: got v=%b len=%0d want 1/%0d", k, core_valid, core_ref_len, exp_len); end
         core_ready = 1'b1;
         step();
         core_ready = 1'b0;
         core_res_valid = 1'b1; core_score = 10'(k + 1); core_column = 7'(k); core_row = 7'(k + 2);
         step();
         core_res_valid = 1'b0;
         n_cmp++; if ({resp_valid, resp_id, resp_tag, resp_score} !== {1'b1, g[0], exp_tag[k], 10'(k + 1)}) begin n_bad++; $display("FAIL rr_resp[%0d]: got v=%b id=%0d tag=%h score=%0d want 1/%0d/%h/%0d", k, resp_valid, resp_id, resp_tag, resp_score, g, exp_tag[k], k + 1); end
         $display("txn rr id=%0d tag=%h score=%0d col=%0d row=%0d", resp_id, resp_tag, resp_score, resp_column, resp_row);
         resp_ready = 1'b1;
         step();
         resp_ready = 1'b0;
      end
      req_valid = 2'b00;
      n_cmp++; if ({stat_jobs, stat_busy} !== {16'd5, 24'd10}) begin n_bad++; $display("FAIL rr_stats: got jobs=%0d busy=%0d want 5/10", stat_jobs, stat_busy); end
   endtask

   // ------------------------------------------------------------ core stall
   task automatic test_core_stall();
      set_req(0, seq_full, seq_b, 8'd128, 8'd1, 4'h3);
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL stall_grant: got %b want 01", req_ready); end
      step();
      req_valid = 2'b00;
      for (int c = 0; c < 10; c++) begin
         n_cmp++; if ({core_valid, core_ref_len, core_read_len, core_ref} !== {1'b1, 8'd128, 8'd1, seq_full}) begin n_bad++; $display("FAIL stall_hold[%0d]: got v=%b len=%0d/%0d want 1/128/1", c, core_valid, core_ref_len, core_read_len); end
         step();
      end
      core_ready = 1'b1;
      n_cmp++; if (core_valid !== 1'b1) begin n_bad++; $display("FAIL stall_last: got %b want 1", core_valid); end
      step();
      core_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if ({core_valid, core_res_ready, resp_valid} !== 3'b010) begin n_bad++; $display("FAIL stall_wait[%0d]: got %b want 010", c, {core_valid, core_res_ready, resp_valid}); end
         step();
      end
      core_res_valid = 1'b1; core_score = -10'sd5; core_column = 7'd127; core_row = 7'd0;
      step();
      core_res_valid = 1'b0;
      n_cmp++; if ({resp_valid, resp_score, resp_column, resp_row} !== {1'b1, -10'sd5, 7'd127, 7'd0}) begin n_bad++; $display("FAIL stall_resp: got v=%b score=%0d col=%0d row=%0d want 1/-5/127/0", resp_valid, resp_score, resp_column, resp_row); end
      $display("txn stall id=%0d tag=%h score=%0d col=%0d row=%0d", resp_id, resp_tag, resp_score, resp_column, resp_row);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      // 11 ISSUE cycles (10 stalled + handshake) and 4 WAIT cycles
      n_cmp++; if ({stat_jobs, stat_busy} !== {16'd6, 24'd25}) begin n_bad++; $display("FAIL stall_stats: got jobs=%0d busy=%0d want 6/25", stat_jobs, stat_busy); end
   endtask

   // ------------------------------------------------- response backpressure
   task automatic test_resp_backpressure();
      set_req(1, seq_c, seq_d, 8'd20, 8'd30, 4'h7);
      req_valid = 2'b10;
      #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_grant: got %b want 10", req_ready); end
      step();
      req_valid = 2'b00;
      core_ready = 1'b1;
      step();
      core_ready = 1'b0;
      core_res_valid = 1'b1; core_score = 10'sd100; core_column = 7'd19; core_row = 7'd29;
      step();
      core_res_valid = 1'b0;
      set_req(0, seq_a, seq_b, 8'd4, 8'd4, 4'h1);
      req_valid = 2'b01;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++; if ({resp_valid, resp_id, resp_tag, resp_score, resp_column, resp_row, resp_err} !== {1'b1, 1'b1, 4'h7, 10'sd100, 7'd19, 7'd29, 1'b0}) begin n_bad++; $display("FAIL bp_stable[%0d]: got v=%b id=%0d tag=%h score=%0d col=%0d row=%0d", c, resp_valid, resp_id, resp_tag, resp_score, resp_column, resp_row); end
         n_cmp++; if ({req_ready, core_valid} !== 3'b000) begin n_bad++; $display("FAIL bp_no_grant[%0d]: got ready=%b core_valid=%b want 00/0", c, req_ready, core_valid); end
         step();
      end
      $display("txn bp id=%0d tag=%h score=%0d col=%0d row=%0d", resp_id, resp_tag, resp_score, resp_column, resp_row);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_regrant: got %b want 01", req_ready); end
      // requester withdraws before the grant edge: nothing is issued
      req_valid = 2'b00;
      step();
      n_cmp++; if ({core_valid, resp_valid} !== 2'b00) begin n_bad++; $display("FAIL bp_withdraw: got core_valid=%b resp_valid=%b want 0/0", core_valid, resp_valid); end
      n_cmp++; if ({stat_jobs, stat_busy} !== {16'd7, 24'd27}) begin n_bad++; $display("FAIL bp_stats: got jobs=%0d busy=%0d want 7/27", stat_jobs, stat_busy); end
   endtask

   // --------------------------------------------------------- reset mid job
   task automatic test_reset_mid_job();
      set_req(0, seq_a, seq_b, 8'd8, 8'd8, 4'h2);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      core_ready = 1'b1;
      step();
      core_ready = 1'b0;
      n_cmp++; if (core_res_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_wait: got %b want 1", core_res_ready); end
      rst_n = 1'b0;
      #2;
      n_cmp++; if ({core_valid, core_res_ready, resp_valid, resp_err, req_ready} !== 6'd0) begin n_bad++; $display("FAIL rst_mid_flags: got %b want 000000", {core_valid, core_res_ready, resp_valid, resp_err, req_ready}); end
      n_cmp++; if ({stat_jobs, stat_busy, core_ref_len, resp_tag, resp_score} !== 62'd0) begin n_bad++; $display("FAIL rst_mid_data: got jobs=%0d busy=%0d len=%0d tag=%0d score=%0d want 0", stat_jobs, stat_busy, core_ref_len, resp_tag, resp_score); end
      #2 rst_n = 1'b1;
      core_res_valid = 1'b1; core_score = 10'sd50; core_column = 7'd3; core_row = 7'd4;
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++; if ({resp_valid, core_res_ready, core_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_late_result[%0d]: got %b want 000", c, {resp_valid, core_res_ready, core_valid}); end
      end
      core_res_valid = 1'b0;
      n_cmp++; if ({stat_jobs, stat_busy} !== 40'd0) begin n_bad++; $display("FAIL rst_late_stats: got jobs=%0d busy=%0d want 0/0", stat_jobs, stat_busy); end
   endtask

   initial begin
      seq_a    = {16'h1B6C, 240'h0};
      seq_b    = {16'h1B2C, 240'h0};
      seq_c    = {32'hE4E4_1234, 224'h0};
      seq_d    = {24'h0F0F0F, 232'h0};
      seq_full = {64{4'b1001}};
      test_reset();
      test_single();
      test_error();
      test_round_robin();
      test_core_stall();
      test_resp_backpressure();
      test_reset_mid_job();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
